demux7_dispatch: RTL and testbench

//   1-to-7 registered dispatcher: the reverse of the 7-way write-data select. Takes one 32-bit

---
 rtl/demux7_dispatch.sv | 103 ++++++++++
 tb/tb_demux7_dispatch.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/demux7_dispatch.sv
// 1-to-7 registered result dispatcher with per-port one-entry holding registers and valid/ack handshake.
// Optional sticky invalid-select flag enabled by defining DEMUX7_ERR_EN.
module demux7_dispatch #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [2:0]            in_sel,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [6:0]            out_valid,
  output logic [7*DATA_W-1:0]   out_data,
  input  logic [6:0]            out_ack,
  output logic [CNT_W-1:0]      xfer_cnt,
  output logic                  err
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } port_state_t;

  localparam int         NPORT    = 7;
  localparam logic [2:0] SEL_DROP = 3'd7;

  logic [NPORT-1:0] w_hit;
  logic             w_sel_drop;
  logic             w_accept;
  logic [CNT_W-1:0] r_xfer_cnt;

  assign w_sel_drop = (in_sel == SEL_DROP);

  // Select 7 hits no port, so it is always ready and simply dropped.
  assign in_ready = ~|(w_hit & out_valid & ~out_ack);
  assign w_accept = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_port
      port_state_t       r_state;
      port_state_t       w_state_next;
      logic [DATA_W-1:0] r_data;
      logic              w_acc;

      assign w_hit[gi] = (in_sel == 3'(gi));
      assign w_acc     = w_accept & w_hit[gi];

      always_ff @(posedge clk) begin
        if (reset) begin
          r_state <= ST_EMPTY;
          r_data  <= '0;
        end else begin
          r_state <= w_state_next;
          if (w_acc) begin
            r_data <= in_data;
          end
        end
      end

      // An accept wins over a same-cycle ack: the slot is refilled, not emptied.
      always_comb begin
        w_state_next = r_state;
        case (r_state)
          ST_EMPTY: if (w_acc) w_state_next = ST_FULL;
          ST_FULL:  if (!w_acc && out_ack[gi]) w_state_next = ST_EMPTY;
          default:  w_state_next = ST_EMPTY;
        endcase
      end

      assign out_valid[gi]                   = (r_state == ST_FULL);
      assign out_data[gi*DATA_W +: DATA_W]   = r_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_xfer_cnt <= '0;
    end else if (w_accept && !w_sel_drop) begin
      r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
    end
  end

  assign xfer_cnt = r_xfer_cnt;

`ifdef DEMUX7_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (in_valid && w_sel_drop) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_demux7_dispatch.sv
// Directed bench for demux7_dispatch (CNT_W=4 so counter wrap is reachable) with a delivery scoreboard.
module tb_demux7_dispatch;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic [2:0]          in_sel;
  logic [DATA_W-1:0]   in_data;
  logic                in_ready;
  logic [6:0]          out_valid;
  logic [7*DATA_W-1:0] out_data;
  logic [6:0]          out_ack;
  logic [CNT_W-1:0]    xfer_cnt;
  logic                err;

  demux7_dispatch #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ack(out_ack),
    .xfer_cnt(xfer_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                port;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  sb_entry_t         sb_q[$];
  logic [6:0]        m_valid;
  logic [DATA_W-1:0] m_data [7];
  logic [CNT_W-1:0]  m_cnt;
  logic              m_err;
  int                checks = 0;
  int                errors = 0;
  int                step_no = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sb_find(input int port);
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].port == port) return i;
    end
    return -1;
  endfunction

  // One clock cycle of stimulus; the model and scoreboard advance alongside the DUT.
  task automatic step(input logic rst, input logic v, input logic [2:0] sel,
                      input logic [DATA_W-1:0] d, input logic [6:0] ack);
    logic exp_ready;
    logic acc;
    int   idx;
    @(negedge clk);
    reset = rst; in_valid = v; in_sel = sel; in_data = d; out_ack = ack;
    #1;
    exp_ready = (sel == 3'd7) || !m_valid[sel] || ack[sel];
    acc = v && exp_ready;
    if (!rst) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
      for (int n = 0; n < 7; n++) begin
        if (ack[n] && m_valid[n]) begin
          idx = sb_find(n);
          chk($sformatf("sb_entry_p%0d", n), {63'd0, idx >= 0}, 64'd1);
          if (idx >= 0) begin
            chk($sformatf("sb_data_p%0d", n), {32'd0, out_data[n*DATA_W +: DATA_W]},
                {32'd0, sb_q[idx].data});
            sb_q.delete(idx);
          end
        end else if (acc && sel == 3'(n) && m_valid[n]) begin
          idx = sb_find(n);
          if (idx >= 0) sb_q.delete(idx);
        end
      end
      if (acc && sel != 3'd7) sb_q.push_back('{port: int'(sel), data: d});
    end
    @(posedge clk);
    if (rst) begin
      m_valid = '0; m_cnt = '0; m_err = 1'b0;
      for (int n = 0; n < 7; n++) m_data[n] = '0;
      sb_q.delete();
    end else begin
      for (int n = 0; n < 7; n++) begin
        if (acc && sel == 3'(n)) begin
          m_valid[n] = 1'b1;
          m_data[n]  = d;
        end else if (ack[n]) begin
          m_valid[n] = 1'b0;
        end
      end
      if (acc && sel != 3'd7) m_cnt = m_cnt + CNT_W'(1);
`ifdef DEMUX7_ERR_EN
      if (v && sel == 3'd7) m_err = 1'b1;
`endif
    end
    #1;
    step_no++;
    chk("out_valid", {57'd0, out_valid}, {57'd0, m_valid});
    for (int n = 0; n < 7; n++) begin
      chk($sformatf("slice%0d", n), {32'd0, out_data[n*DATA_W +: DATA_W]}, {32'd0, m_data[n]});
    end
    chk("xfer_cnt", {60'd0, xfer_cnt}, {60'd0, m_cnt});
    chk("err", {63'd0, err}, {63'd0, m_err});
    $display("step %0d: rst=%0b v=%0b sel=%0d data=%08h ack=%07b -> valid=%07b cnt=%0d err=%0b",
             step_no, rst, v, sel, d, ack, out_valid, xfer_cnt, err);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = '0; out_ack = '0;
    m_valid = '0; m_cnt = '0; m_err = 1'b0;
    for (int n = 0; n < 7; n++) m_data[n] = '0;

    step(1, 0, 0, 0, 7'h00);
    step(1, 0, 0, 0, 7'h00);

    // Single transfer to port 3.
    step(0, 1, 3, 32'hDEADBEEF, 7'h00);
    // Port 5 full, blocked offer, then pass-through on ack.
    step(0, 1, 5, 32'hAAAA5555, 7'h00);
    step(0, 1, 5, 32'hBBBB0000, 7'h00);
    step(0, 1, 5, 32'h12345678, 7'b0100000);
    // Port 0 acked while port 2 accepts.
    step(0, 1, 0, 32'h0000C0DE, 7'h00);
    step(0, 1, 2, 32'h22222222, 7'b0000001);
    // Invalid select is accepted and dropped.
    step(0, 1, 7, 32'hFFFFFFFF, 7'h00);
    step(0, 0, 7, 32'h0BADF00D, 7'h00);
    // Acks on empty ports and idle garbage inputs change nothing.
    step(0, 0, 1, 32'h99999999, 7'b1000010);
    // Drain everything.
    step(0, 0, 0, 0, 7'h7F);

    // Fill 1,4,6 then reset with a concurrent offer.
    step(0, 1, 1, 32'h11110001, 7'h00);
    step(0, 1, 4, 32'h44440004, 7'h00);
    step(0, 1, 6, 32'h66660006, 7'h00);
    step(1, 1, 2, 32'h22220002, 7'b1111111);

    // 17 accepts to port 0, each acked, to wrap the 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 0, 32'h1000 + i, 7'h00);
      step(0, 0, 0, 0, 7'b0000001);
    end

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      step(0, $urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, 7'($urandom));
    end
    step(0, 0, 0, 0, 7'h7F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
